// File: rtl/stack_ctrl.sv
// stack_ctrl: stack-pointer sequencer for the calculator CPU hardware stack.
// Turns PUSH/POP/CALL/RET strobes into single-port synchronous RAM accesses.
//
// Ports:
//   CLK, RST      clock (rising edge), synchronous active-low reset
//   start, op     request strobe (IDLE only) and opcode 00 PUSH 01 POP 10 CALL 11 RET
//   data_in       PUSH operand
//   pc_in         CALL return address
//   clr_err       clears sticky ovf/unf
//   mem_*         stack-RAM port (mem_rdata valid one cycle after mem_re)
//   sp_out        stack pointer
//   full, empty   stack level flags
//   busy, done    request in flight / one-cycle completion pulse
//   err           with done: request was rejected
//   pop_data      last POP result
//   ret_pc        last RET result
//   ovf, unf      sticky overflow / underflow
module stack_ctrl #(
   parameter int             DW        = 16,
   parameter int             AW        = 16,
   parameter logic [AW-1:0]  SP_TOP    = 16'h01FF,
   parameter logic [AW-1:0]  SP_BOTTOM = 16'h0100
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          start,
   input  logic [1:0]    op,
   input  logic [DW-1:0] data_in,
   input  logic [DW-1:0] pc_in,
   input  logic [DW-1:0] mem_rdata,
   input  logic          clr_err,
   output logic [AW-1:0] mem_addr,
   output logic          mem_we,
   output logic          mem_re,
   output logic [DW-1:0] mem_wdata,
   output logic [AW-1:0] sp_out,
   output logic          busy,
   output logic          done,
   output logic          err,
   output logic [DW-1:0] pop_data,
   output logic [DW-1:0] ret_pc,
   output logic          full,
   output logic          empty,
   output logic          ovf,
   output logic          unf
);

   typedef enum logic [2:0] {
      IDLE,
      WRITE,
      READ,
      WAIT,
      DONE
   } state_t;

   localparam logic [1:0]    OP_CALL = 2'b10;
   localparam logic [AW-1:0] SP_FULL = SP_BOTTOM - AW'(1);

   state_t        state;
   logic [AW-1:0] sp;
   logic [DW-1:0] operand;
   logic          ret_q;
   logic          err_q;

   // op[0] set means a pop-type request (POP/RET); op[1] picks CALL/RET.
   logic is_pop;
   assign is_pop = op[0];

   assign sp_out = sp;
   assign full   = (sp == SP_FULL);
   assign empty  = (sp == SP_TOP);
   assign busy   = (state != IDLE);
   assign done   = (state == DONE);
   assign err    = done & err_q;

   // RAM strobes are gated by reset so an aborted access never lands.
   assign mem_we    = RST & (state == WRITE);
   assign mem_re    = RST & (state == READ);
   assign mem_wdata = (state == WRITE) ? operand : '0;
   assign mem_addr  = (state == WRITE) ? sp :
                      (state == READ)  ? sp + AW'(1) : '0;

   always_ff @(posedge CLK) begin
      if (!RST) begin
         state    <= IDLE;
         sp       <= SP_TOP;
         operand  <= '0;
         ret_q    <= 1'b0;
         err_q    <= 1'b0;
         pop_data <= '0;
         ret_pc   <= '0;
         ovf      <= 1'b0;
         unf      <= 1'b0;
      end else begin
         // Clear first; a set later in this block overrides it.
         if (clr_err) begin
            ovf <= 1'b0;
            unf <= 1'b0;
         end
         unique case (state)
            IDLE: begin
               if (start) begin
                  ret_q   <= op[1];
                  operand <= (op == OP_CALL) ? pc_in : data_in;
                  if (!is_pop && full) begin
                     err_q <= 1'b1;
                     ovf   <= 1'b1;
                     state <= DONE;
                  end else if (is_pop && empty) begin
                     err_q <= 1'b1;
                     unf   <= 1'b1;
                     state <= DONE;
                  end else begin
                     err_q <= 1'b0;
                     state <= is_pop ? READ : WRITE;
                  end
               end
            end
            WRITE: begin
               sp    <= sp - AW'(1);
               state <= DONE;
            end
            READ: begin
               sp    <= sp + AW'(1);
               state <= WAIT;
            end
            WAIT: begin
               if (ret_q) ret_pc <= mem_rdata;
               else       pop_data <= mem_rdata;
               state <= DONE;
            end
            DONE: begin
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_stack_ctrl.sv
// tb_stack_ctrl: self-checking bench for stack_ctrl.
// Table vectors, hand-written corner sequences, and a random run vs a queue model.
module tb_stack_ctrl;

   logic        CLK = 1'b0;
   logic        RST;
   logic        start;
   logic [1:0]  op;
   logic [15:0] data_in;
   logic [15:0] pc_in;
   logic [15:0] mem_rdata;
   logic        clr_err;
   logic [15:0] mem_addr;
   logic        mem_we;
   logic        mem_re;
   logic [15:0] mem_wdata;
   logic [15:0] sp_out;
   logic        busy;
   logic        done;
   logic        err;
   logic [15:0] pop_data;
   logic [15:0] ret_pc;
   logic        full;
   logic        empty;
   logic        ovf;
   logic        unf;

   int checks = 0;
   int failures = 0;

   localparam logic [1:0] PUSH = 2'b00;
   localparam logic [1:0] POP  = 2'b01;
   localparam logic [1:0] CALL = 2'b10;
   localparam logic [1:0] RET  = 2'b11;

   stack_ctrl dut (
      .CLK(CLK), .RST(RST), .start(start), .op(op),
      .data_in(data_in), .pc_in(pc_in), .mem_rdata(mem_rdata),
      .clr_err(clr_err), .mem_addr(mem_addr), .mem_we(mem_we),
      .mem_re(mem_re), .mem_wdata(mem_wdata), .sp_out(sp_out),
      .busy(busy), .done(done), .err(err), .pop_data(pop_data),
      .ret_pc(ret_pc), .full(full), .empty(empty), .ovf(ovf), .unf(unf)
   );

   always #5 CLK = ~CLK;

   // Synchronous single-port RAM, one-cycle read latency.
   logic [15:0] ram [0:65535];
   always @(posedge CLK) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      if (mem_re) mem_rdata <= ram[mem_addr];
   end

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge CLK);
      RST = 1'b0;
      repeat (2) @(negedge CLK);
      RST = 1'b1;
   endtask

   // Issues one request; returns at the negedge of the done cycle
   // (lat = cycles after the accept edge, 0 on timeout).
   task automatic req(input logic [1:0] o, input logic [15:0] d,
                      input logic [15:0] p, output int lat,
                      output logic e, output int nwe, output int nre,
                      output logic [15:0] awr, output logic [15:0] wd,
                      output logic [15:0] ard);
      lat = 0; e = 1'b0; nwe = 0; nre = 0;
      awr = '0; wd = '0; ard = '0;
      @(negedge CLK);
      start = 1'b1; op = o; data_in = d; pc_in = p;
      @(negedge CLK);
      start = 1'b0;
      for (int c = 1; c <= 8; c++) begin
         if (mem_we) begin nwe++; awr = mem_addr; wd = mem_wdata; end
         if (mem_re) begin nre++; ard = mem_addr; end
         if (done) begin
            lat = c;
            e = err;
            break;
         end
         @(negedge CLK);
      end
   endtask

   task automatic pulse_clr();
      @(negedge CLK);
      clr_err = 1'b1;
      @(negedge CLK);
      clr_err = 1'b0;
   endtask

   typedef struct {
      logic [1:0]  op;
      logic [15:0] din;
      logic [15:0] pc;
      logic        e_err;
      int          e_lat;
      logic [15:0] e_val;
      logic [15:0] e_sp;
   } vec_t;

   vec_t vec [8];

   int          lat, nwe, nre;
   logic        e;
   logic [15:0] awr, wd, ard;
   logic [15:0] q [$];
   logic        m_ovf, m_unf, m_err;
   logic [15:0] m_val;
   int          m_lat;
   logic [15:0] rv;
   logic [1:0]  ro;
   int          pct;
   int          saw_done;

   initial begin
      RST = 1'b0; start = 1'b0; op = '0;
      data_in = '0; pc_in = '0; clr_err = 1'b0;

      vec[0] = '{PUSH, 16'h1111, 16'h0000, 1'b0, 2, 16'h0000, 16'h01FE};
      vec[1] = '{PUSH, 16'h2222, 16'h0000, 1'b0, 2, 16'h0000, 16'h01FD};
      vec[2] = '{CALL, 16'hFFFF, 16'h0333, 1'b0, 2, 16'h0000, 16'h01FC};
      vec[3] = '{RET,  16'h0000, 16'h0000, 1'b0, 3, 16'h0333, 16'h01FD};
      vec[4] = '{POP,  16'h0000, 16'h0000, 1'b0, 3, 16'h2222, 16'h01FE};
      vec[5] = '{POP,  16'h0000, 16'h0000, 1'b0, 3, 16'h1111, 16'h01FF};
      vec[6] = '{RET,  16'h0000, 16'h0000, 1'b1, 1, 16'h0333, 16'h01FF};
      vec[7] = '{POP,  16'h0000, 16'h0000, 1'b1, 1, 16'h1111, 16'h01FF};

      // Reset state
      repeat (2) @(negedge CLK);
      chk("rst_sp", sp_out, 16'h01FF);
      chk("rst_empty", empty, 1'b1);
      chk("rst_full", full, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_we", mem_we, 1'b0);
      chk("rst_re", mem_re, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_err", err, 1'b0);
      chk("rst_addr", mem_addr, 16'h0000);
      chk("rst_popd", pop_data, 16'h0000);
      chk("rst_retpc", ret_pc, 16'h0000);
      chk("rst_flags", {ovf, unf}, 2'b00);
      RST = 1'b1;

      // Table vectors
      for (int i = 0; i < 8; i++) begin
         req(vec[i].op, vec[i].din, vec[i].pc, lat, e, nwe, nre, awr, wd, ard);
         chk($sformatf("vec%0d_lat", i), lat, vec[i].e_lat);
         chk($sformatf("vec%0d_err", i), e, vec[i].e_err);
         chk($sformatf("vec%0d_sp", i), sp_out, vec[i].e_sp);
         chk($sformatf("vec%0d_ram", i), nwe + nre,
             vec[i].e_err ? 0 : 1);
         if (vec[i].op == RET)
            chk($sformatf("vec%0d_retpc", i), ret_pc, vec[i].e_val);
         else if (vec[i].op == POP)
            chk($sformatf("vec%0d_popd", i), pop_data, vec[i].e_val);
      end
      chk("vec_unf", unf, 1'b1);
      pulse_clr();
      chk("vec_clr_unf", unf, 1'b0);

      // PUSH / POP strobe details
      do_reset();
      req(PUSH, 16'hABCD, 16'h0, lat, e, nwe, nre, awr, wd, ard);
      chk("push_lat", lat, 2);
      chk("push_we", nwe, 1);
      chk("push_addr", awr, 16'h01FF);
      chk("push_wdata", wd, 16'hABCD);
      chk("push_sp", sp_out, 16'h01FE);
      req(POP, 16'h0, 16'h0, lat, e, nwe, nre, awr, wd, ard);
      chk("pop_lat", lat, 3);
      chk("pop_re", nre, 1);
      chk("pop_addr", ard, 16'h01FF);
      chk("pop_data", pop_data, 16'hABCD);
      chk("pop_sp", sp_out, 16'h01FF);

      // POP on empty
      req(POP, 16'h0, 16'h0, lat, e, nwe, nre, awr, wd, ard);
      chk("unf_lat", lat, 1);
      chk("unf_err", e, 1'b1);
      chk("unf_re", nre, 0);
      chk("unf_flag", unf, 1'b1);
      chk("unf_sp", sp_out, 16'h01FF);
      pulse_clr();
      chk("unf_clr", unf, 1'b0);

      // Fill to capacity, then overflow
      for (int i = 0; i < 256; i++)
         req(PUSH, 16'(i), 16'h0, lat, e, nwe, nre, awr, wd, ard);
      chk("fill_sp", sp_out, 16'h00FF);
      chk("fill_full", full, 1'b1);
      chk("fill_ovf", ovf, 1'b0);
      req(PUSH, 16'hDEAD, 16'h0, lat, e, nwe, nre, awr, wd, ard);
      chk("ovf_err", e, 1'b1);
      chk("ovf_we", nwe, 0);
      chk("ovf_flag", ovf, 1'b1);
      chk("ovf_sp", sp_out, 16'h00FF);
      pulse_clr();
      chk("ovf_clr", ovf, 1'b0);
      // Set and clear on the same edge: set wins
      @(negedge CLK);
      start = 1'b1; op = CALL; pc_in = 16'hBEEF; clr_err = 1'b1;
      @(negedge CLK);
      start = 1'b0; clr_err = 1'b0;
      chk("setwin_ovf", ovf, 1'b1);
      chk("setwin_done", done, 1'b1);
      req(POP, 16'h0, 16'h0, lat, e, nwe, nre, awr, wd, ard);
      chk("top_popd", pop_data, 16'h00FF);
      chk("top_sp", sp_out, 16'h0100);

      // CALL / RET, then reset during WRITE
      do_reset();
      req(CALL, 16'h5A5A, 16'h0123, lat, e, nwe, nre, awr, wd, ard);
      chk("call_wdata", wd, 16'h0123);
      req(RET, 16'h0, 16'h0, lat, e, nwe, nre, awr, wd, ard);
      chk("ret_pc", ret_pc, 16'h0123);
      chk("ret_sp", sp_out, 16'h01FF);
      @(negedge CLK);
      start = 1'b1; op = PUSH; data_in = 16'h5555;
      @(negedge CLK);
      start = 1'b0;
      chk("abort_we_pre", mem_we, 1'b1);
      RST = 1'b0;
      #1;
      chk("abort_we_gate", mem_we, 1'b0);
      @(negedge CLK);
      chk("abort_busy", busy, 1'b0);
      chk("abort_sp", sp_out, 16'h01FF);
      saw_done = 0;
      RST = 1'b1;
      for (int c = 0; c < 4; c++) begin
         if (done) saw_done++;
         @(negedge CLK);
      end
      chk("abort_nodone", saw_done, 0);

      // Random run against a queue model
      do_reset();
      q.delete();
      m_ovf = 1'b0; m_unf = 1'b0;
      for (int i = 0; i < 1200; i++) begin
         pct = (i < 600) ? 85 : 15;
         if ($urandom_range(0, 15) == 0) begin
            pulse_clr();
            m_ovf = 1'b0; m_unf = 1'b0;
         end
         rv = 16'($urandom);
         if ($urandom_range(0, 99) < pct)
            ro = $urandom_range(0, 1) ? CALL : PUSH;
         else
            ro = $urandom_range(0, 1) ? RET : POP;
         m_val = (ro == RET) ? ret_pc : pop_data;
         if (!ro[0]) begin
            if (q.size() == 256) begin
               m_err = 1'b1; m_lat = 1; m_ovf = 1'b1;
            end else begin
               m_err = 1'b0; m_lat = 2; q.push_back(rv);
            end
         end else begin
            if (q.size() == 0) begin
               m_err = 1'b1; m_lat = 1; m_unf = 1'b1;
            end else begin
               m_err = 1'b0; m_lat = 3; m_val = q.pop_back();
            end
         end
         req(ro, rv, rv, lat, e, nwe, nre, awr, wd, ard);
         chk("rnd_lat", lat, m_lat);
         chk("rnd_err", e, m_err);
         chk("rnd_sp", sp_out, 16'h01FF - 16'(q.size()));
         chk("rnd_flags", {ovf, unf}, {m_ovf, m_unf});
         chk("rnd_lvl", {full, empty}, {q.size() == 256, q.size() == 0});
         if (ro[0])
            chk("rnd_val", (ro == RET) ? ret_pc : pop_data, m_val);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
